mem_bus_bridge: RTL and testbench

- Sits directly downstream of the multicycle CPU core.
- Merges the core's instruction-fetch request (IM_R, pc_out) and data request (DM_CS/DM_R/DM_W, maddr, mwdata) onto one single-port, variable-latency memory bus with a req/ack handshake.
- Returns inst and mrdata to the core, plus a stall signal that the core's control FSM uses to hold its current state.
- Flags misaligned accesses and bus timeouts.

---
 rtl/mem_bus_bridge.sv | 141 ++++++++++++++
 tb/tb_mem_bus_bridge.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/mem_bus_bridge.sv
// rtl/mem_bus_bridge.sv - arbitrates CPU fetch/data requests onto one req/ack memory bus
module mem_bus_bridge #(
  parameter int          TIMEOUT  = 16,
  parameter logic [31:0] ERR_DATA = 32'hDEADBEEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        IM_R,
  input  logic [31:0] pc_out,
  input  logic        DM_CS,
  input  logic        DM_R,
  input  logic        DM_W,
  input  logic [31:0] maddr,
  input  logic [31:0] mwdata,
  output logic [31:0] inst,
  output logic [31:0] mrdata,
  output logic        stall,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack,
  output logic        align_err,
  output logic        bus_err
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] TMO_LIMIT = CW'(TIMEOUT);

  typedef enum logic [2:0] {IDLE, IFETCH, DREAD, DWRITE, DONE} state_t;

  state_t        state, next_state, sel_state;
  logic [31:0]   sel_addr;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_inc;
  logic          issue, misalign, waiting, ack_ok, tmo;

  assign cnt_inc = cnt + CW'(1);

  // State register; reset always lands in IDLE so a late ack is ignored.
  always_ff @(posedge clk) begin
    if (!reset) state <= IDLE;
    else        state <= next_state;
  end

  // Request selection, bus completion/timeout decisions and the stall output.
  always_comb begin
    next_state = state;
    sel_state  = IDLE;
    sel_addr   = pc_out;
    issue      = 1'b0;
    misalign   = 1'b0;
    waiting    = 1'b0;
    ack_ok     = 1'b0;
    tmo        = 1'b0;
    stall      = 1'b0;
    case (state)
      IDLE: begin
        if (DM_CS && DM_W) begin
          sel_state = DWRITE;
          sel_addr  = maddr;
        end else if (DM_CS && DM_R) begin
          sel_state = DREAD;
          sel_addr  = maddr;
        end else if (IM_R) begin
          sel_state = IFETCH;
          sel_addr  = pc_out;
        end
        if (sel_state != IDLE) begin
          stall = 1'b1;
          if (sel_addr[1:0] != 2'b00) begin
            misalign   = 1'b1;
            next_state = DONE;
          end else begin
            issue      = 1'b1;
            next_state = sel_state;
          end
        end
      end
      IFETCH, DREAD, DWRITE: begin
        stall   = 1'b1;
        waiting = 1'b1;
        // An ack on the edge where the count hits the limit still wins.
        if (mem_ack) begin
          ack_ok     = 1'b1;
          next_state = DONE;
        end else if (cnt_inc == TMO_LIMIT) begin
          tmo        = 1'b1;
          next_state = DONE;
        end
      end
      DONE: next_state = IDLE;
      default: next_state = IDLE;
    endcase
    if (!reset) stall = 1'b0;
  end

  // Bus outputs, timeout counter, returned data and sticky error flags.
  always_ff @(posedge clk) begin
    if (!reset) begin
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      inst      <= '0;
      mrdata    <= '0;
      align_err <= 1'b0;
      bus_err   <= 1'b0;
      cnt       <= '0;
    end else begin
      if (issue) begin
        mem_req  <= 1'b1;
        mem_we   <= (sel_state == DWRITE);
        mem_addr <= sel_addr;
        if (sel_state == DWRITE) mem_wdata <= mwdata;
        cnt      <= '0;
      end
      if (misalign) align_err <= 1'b1;
      if (waiting) begin
        if (ack_ok) begin
          mem_req <= 1'b0;
          mem_we  <= 1'b0;
          cnt     <= '0;
          if (state == IFETCH) inst   <= mem_rdata;
          if (state == DREAD)  mrdata <= mem_rdata;
        end else if (tmo) begin
          mem_req <= 1'b0;
          mem_we  <= 1'b0;
          cnt     <= '0;
          bus_err <= 1'b1;
          if (state == IFETCH) inst   <= ERR_DATA;
          if (state == DREAD)  mrdata <= ERR_DATA;
        end else begin
          cnt <= cnt_inc;
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_bus_bridge.sv
// tb/tb_mem_bus_bridge.sv - randomized transaction-level check of mem_bus_bridge
module tb_mem_bus_bridge;

  localparam int          TMO = 16;
  localparam logic [31:0] ERR = 32'hDEADBEEF;

  logic        clk = 1'b0;
  logic        reset;
  logic        IM_R, DM_CS, DM_R, DM_W;
  logic [31:0] pc_out, maddr, mwdata;
  logic [31:0] inst, mrdata, mem_addr, mem_wdata, mem_rdata;
  logic        stall, mem_req, mem_we, mem_ack, align_err, bus_err;

  int passed = 0;
  int total  = 0;

  logic [31:0] exp_inst, exp_mrdata;
  logic        exp_align, exp_bus;

  mem_bus_bridge #(.TIMEOUT(TMO), .ERR_DATA(ERR)) dut (
    .clk(clk), .reset(reset), .IM_R(IM_R), .pc_out(pc_out),
    .DM_CS(DM_CS), .DM_R(DM_R), .DM_W(DM_W), .maddr(maddr), .mwdata(mwdata),
    .inst(inst), .mrdata(mrdata), .stall(stall),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .align_err(align_err), .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  // One complete core request. ack_at = n acks on the n-th cycle mem_req is high;
  // ack_at outside 1..TMO means the bus never answers.
  task automatic run_txn(input logic im, input logic [31:0] pc, input logic cs,
                         input logic r, input logic w, input logic [31:0] ma,
                         input logic [31:0] wd, input int ack_at,
                         input logic [31:0] rd, input logic keep_im);
    int          kind;
    logic [31:0] a, a0, wd0;
    logic        mis, we0, unstable, fin, acked;
    int          st_n, rq_n, exp_stall, exp_req;
    kind  = (cs && w) ? 3 : (cs && r) ? 2 : 1;
    a     = (kind == 1) ? pc : ma;
    mis   = (a % 4) != 0;
    acked = (ack_at >= 1) && (ack_at <= TMO);
    exp_stall = mis ? 1 : (acked ? ack_at + 1 : TMO + 1);
    exp_req   = mis ? 0 : (acked ? ack_at : TMO);

    @(negedge clk);
    IM_R = im; pc_out = pc; DM_CS = cs; DM_R = r; DM_W = w; maddr = ma; mwdata = wd;
    mem_ack = 1'b0;
    st_n = 0; rq_n = 0; unstable = 1'b0; fin = 1'b0;
    a0 = '0; wd0 = '0; we0 = 1'b0;
    for (int c = 0; c < TMO + 8 && !fin; c++) begin
      #1;
      if (!stall) begin
        fin = 1'b1;
      end else begin
        st_n++;
        if (mem_req) begin
          rq_n++;
          if (rq_n == 1) begin
            a0 = mem_addr; we0 = mem_we; wd0 = mem_wdata;
          end else if (mem_addr !== a0 || mem_we !== we0 || mem_wdata !== wd0) begin
            unstable = 1'b1;
          end
          mem_ack   = (rq_n == ack_at);
          mem_rdata = mem_ack ? rd : $urandom;
        end else begin
          mem_ack = 1'b0;
        end
        @(negedge clk);
        mem_ack = 1'b0;
      end
    end

    if (!mis && acked) begin
      if (kind == 1) exp_inst   = rd;
      if (kind == 2) exp_mrdata = rd;
    end else if (!mis) begin
      exp_bus = 1'b1;
      if (kind == 1) exp_inst   = ERR;
      if (kind == 2) exp_mrdata = ERR;
    end
    if (mis) exp_align = 1'b1;

    check("done_reached", 32'(fin), 32'd1);
    check("stall_cycles", 32'(st_n), 32'(exp_stall));
    check("req_cycles", 32'(rq_n), 32'(exp_req));
    if (rq_n > 0) begin
      check("bus_stable", 32'(unstable), 32'd0);
      check("mem_addr", a0, a);
      check("mem_we", 32'(we0), 32'(kind == 3));
      if (kind == 3) check("mem_wdata", wd0, wd);
    end
    check("done_req", 32'(mem_req), 32'd0);
    check("done_we", 32'(mem_we), 32'd0);
    check("inst", inst, exp_inst);
    check("mrdata", mrdata, exp_mrdata);
    check("align_err", 32'(align_err), 32'(exp_align));
    check("bus_err", 32'(bus_err), 32'(exp_bus));

    DM_CS = 1'b0; DM_R = 1'b0; DM_W = 1'b0;
    if (!keep_im) IM_R = 1'b0;
  endtask

  initial begin
    logic [31:0] p, m;
    int          k, sel, ack;
    reset = 1'b0; IM_R = 1'b1; DM_CS = 1'b0; DM_R = 1'b0; DM_W = 1'b0;
    pc_out = 32'h40; maddr = '0; mwdata = '0; mem_rdata = '0; mem_ack = 1'b0;
    exp_inst = '0; exp_mrdata = '0; exp_align = 1'b0; exp_bus = 1'b0;

    repeat (3) @(negedge clk);
    #1;
    check("rst_stall", 32'(stall), 32'd0);
    check("rst_req", 32'(mem_req), 32'd0);
    check("rst_we", 32'(mem_we), 32'd0);
    check("rst_addr", mem_addr, 32'd0);
    check("rst_wdata", mem_wdata, 32'd0);
    check("rst_inst", inst, 32'd0);
    check("rst_mrdata", mrdata, 32'd0);
    check("rst_flags", {30'd0, align_err, bus_err}, 32'd0);
    IM_R = 1'b0;
    reset = 1'b1;

    // fetch with ack on third request cycle
    run_txn(1'b1, 32'h40, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 3, 32'h8C220004, 1'b0);
    // store with immediate ack
    run_txn(1'b0, 32'h0, 1'b1, 1'b0, 1'b1, 32'h100, 32'h1234ABCD, 1, 32'h0BAD0BAD, 1'b0);
    // read beats a simultaneous fetch; fetch follows once back in IDLE
    run_txn(1'b1, 32'h80, 1'b1, 1'b1, 1'b0, 32'h200, 32'h0, 2, 32'hCAFE0001, 1'b1);
    run_txn(1'b1, 32'h80, 1'b0, 1'b0, 1'b0, 32'h200, 32'h0, 1, 32'hCAFE0002, 1'b0);
    // misaligned read
    run_txn(1'b0, 32'h0, 1'b1, 1'b1, 1'b0, 32'h102, 32'h0, 1, 32'h11111111, 1'b0);
    // ack exactly on the timeout edge still succeeds
    run_txn(1'b0, 32'h0, 1'b1, 1'b1, 1'b0, 32'h204, 32'h0, TMO, 32'h600DF00D, 1'b0);
    // fetch that never gets an ack
    run_txn(1'b1, 32'h44, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 0, 32'h0, 1'b0);

    for (int t = 0; t < 24; t++) begin
      k = $urandom_range(0, 2);
      p = $urandom; m = $urandom;
      p[1:0] = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      m[1:0] = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      sel = $urandom_range(0, 9);
      ack = (sel == 0) ? 0 : (sel == 1) ? TMO : $urandom_range(1, 4);
      case (k)
        0: run_txn(1'b1, p, 1'b0, 1'($urandom), 1'($urandom), m, $urandom, ack, $urandom, 1'b0);
        1: run_txn(1'($urandom), p, 1'b1, 1'b1, 1'b0, m, $urandom, ack, $urandom, 1'b0);
        default: run_txn(1'($urandom), p, 1'b1, 1'($urandom), 1'b1, m, $urandom, ack, $urandom, 1'b0);
      endcase
    end

    // reset while a read waits on the bus, then a stray ack
    @(negedge clk);
    DM_CS = 1'b1; DM_R = 1'b1; maddr = 32'h300;
    @(negedge clk);
    #1;
    check("mid_req_up", 32'(mem_req), 32'd1);
    DM_CS = 1'b0; DM_R = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("mid_stall_forced", 32'(stall), 32'd0);
    @(negedge clk);
    #1;
    check("mid_req_drop", 32'(mem_req), 32'd0);
    check("mid_flags", {30'd0, align_err, bus_err}, 32'd0);
    check("mid_inst", inst, 32'd0);
    check("mid_mrdata", mrdata, 32'd0);
    reset = 1'b1;
    mem_ack = 1'b1; mem_rdata = 32'h55AA55AA;
    @(negedge clk);
    mem_ack = 1'b0;
    #1;
    check("late_ack_mrdata", mrdata, 32'd0);
    check("late_ack_req", 32'(mem_req), 32'd0);
    check("late_ack_stall", 32'(stall), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
